// File: rtl/img_frame_streamer.sv
// ---------------------------------------------------------------------------
// img_frame_streamer
//   Reads an H_RES x V_RES RGB565 image ROM in raster order and presents it
//   as a valid/ready pixel stream with start-of-frame and end-of-line flags.
//   The ROM is combinational: rom_addr is driven straight from the address
//   register and rom_data is captured into the output register on each load.
//
// Ports
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   start       begin one frame (CONTINUOUS=1: begin streaming), IDLE only
//   busy        high whenever the FSM is not IDLE
//   rom_addr    ROM address (ADDR_W bits)
//   rom_data    ROM read data, combinational in rom_addr
//   m_data      pixel data
//   m_valid     m_data / m_sof / m_eol valid
//   m_ready     consumer accepts the beat when m_valid && m_ready
//   m_sof       beat is pixel (0,0)
//   m_eol       beat is the last pixel of a line
//   frame_done  one-cycle pulse after the last pixel of a frame is accepted
// ---------------------------------------------------------------------------
module img_frame_streamer #(
  parameter int H_RES      = 320,
  parameter int V_RES      = 240,
  parameter int ADDR_W     = $clog2(H_RES * V_RES),
  parameter int DATA_W     = 16,
  parameter bit CONTINUOUS = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_sof,
  output logic              m_eol,
  output logic              frame_done
);

  localparam int X_W = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int Y_W = (V_RES > 1) ? $clog2(V_RES) : 1;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);
  localparam logic [X_W-1:0]    LAST_X    = X_W'(H_RES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [X_W-1:0]    x;
  logic [Y_W-1:0]    y;
  logic              m_last;   // beat in the output register came from LAST_ADDR
  logic              load;
  logic              accept;

  // A new pixel is fetched whenever the output register is empty or is being
  // emptied this cycle; this is what gives one pixel per clock with no bubbles.
  assign load     = (state == RUN) && (!m_valid || m_ready);
  assign accept   = m_valid && m_ready;
  assign busy     = (state != IDLE);
  assign rom_addr = addr;

  // NOTE: every register below is written with <= so all of them update from
  // the same pre-edge values; a blocking = here would let later statements see
  // half-updated state and break the addr/x/y relationship.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      addr       <= '0;
      x          <= '0;
      y          <= '0;
      m_data     <= '0;
      m_valid    <= 1'b0;
      m_sof      <= 1'b0;
      m_eol      <= 1'b0;
      m_last     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept && m_last;

      case (state)
        IDLE: begin
          if (start) begin
            addr  <= '0;
            x     <= '0;
            y     <= '0;
            state <= RUN;
          end
        end

        RUN: begin
          if (load) begin
            m_data  <= rom_data;
            m_sof   <= (addr == '0);
            m_eol   <= (x == LAST_X);
            m_last  <= (addr == LAST_ADDR);
            m_valid <= 1'b1;

            if (x == LAST_X) begin
              x <= '0;
              y <= y + Y_W'(1);
            end else begin
              x <= x + X_W'(1);
            end

            // Frame wrap: the y assignment here overrides the line increment.
            if (addr == LAST_ADDR) begin
              addr <= '0;
              y    <= '0;
              if (!CONTINUOUS) state <= DRAIN;
            end else begin
              addr <= addr + ADDR_W'(1);
            end
          end
        end

        DRAIN: begin
          if (accept) begin
            m_valid <= 1'b0;
            state   <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_img_frame_streamer.sv
// ---------------------------------------------------------------------------
// tb_img_frame_streamer
//   dut0: 4x3 single-frame streamer, dut1: 5x3 continuous streamer.
//   Expected beats are queued when a frame is started; per-DUT monitors pop
//   and compare on every accepted beat, and also watch frame_done timing,
//   output stability under backpressure and the continuous-mode valid gap.
// ---------------------------------------------------------------------------
module tb_img_frame_streamer;

  localparam int H0 = 4;
  localparam int V0 = 3;
  localparam int H1 = 5;
  localparam int V1 = 3;
  localparam int AW0 = $clog2(H0 * V0);
  localparam int AW1 = $clog2(H1 * V1);

  typedef struct {
    logic [15:0] data;
    logic        sof;
    logic        eol;
    logic        last;
  } beat_t;

  logic clk;
  int   n_cmp = 0;
  int   n_err = 0;

  // dut0 signals
  logic           reset_n0, start0, busy0, m_valid0, m_ready0, m_sof0, m_eol0, frame_done0;
  logic [AW0-1:0] rom_addr0;
  logic [15:0]    rom_data0, m_data0;
  // dut1 signals
  logic           reset_n1, start1, busy1, m_valid1, m_ready1, m_sof1, m_eol1, frame_done1;
  logic [AW1-1:0] rom_addr1;
  logic [15:0]    rom_data1, m_data1;

  beat_t q0[$];
  beat_t q1[$];
  int    beats0 = 0, beats1 = 0;
  int    done_cnt0 = 0, done_cnt1 = 0;
  bit    rnd0 = 1'b0;

  function automatic logic [15:0] rom_word(input int a);
    return 16'h5A00 ^ 16'(a * 37);
  endfunction

  assign rom_data0 = rom_word(int'(rom_addr0));
  assign rom_data1 = rom_word(int'(rom_addr1));

  img_frame_streamer #(.H_RES(H0), .V_RES(V0), .DATA_W(16), .CONTINUOUS(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n0), .start(start0), .busy(busy0),
    .rom_addr(rom_addr0), .rom_data(rom_data0), .m_data(m_data0),
    .m_valid(m_valid0), .m_ready(m_ready0), .m_sof(m_sof0), .m_eol(m_eol0),
    .frame_done(frame_done0)
  );

  img_frame_streamer #(.H_RES(H1), .V_RES(V1), .DATA_W(16), .CONTINUOUS(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n1), .start(start1), .busy(busy1),
    .rom_addr(rom_addr1), .rom_data(rom_data1), .m_data(m_data1),
    .m_valid(m_valid1), .m_ready(m_ready1), .m_sof(m_sof1), .m_eol(m_eol1),
    .frame_done(frame_done1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected beats for one frame of an h x v image, in raster order.
  task automatic push_frame(input int sel, input int h, input int v);
    beat_t b;
    for (int i = 0; i < h * v; i++) begin
      b.data = rom_word(i);
      b.sof  = (i == 0);
      b.eol  = ((i % h) == h - 1);
      b.last = (i == h * v - 1);
      if (sel == 0) q0.push_back(b);
      else          q1.push_back(b);
    end
  endtask

  // m_ready for dut0: held high, or a fresh random value each cycle.
  initial begin
    m_ready0 = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      m_ready0 = rnd0 ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ------------------------------------------------------------ monitor dut0
  bit          stall0 = 1'b0, done_exp0 = 1'b0;
  logic [15:0] hold_data0;
  logic        hold_sof0, hold_eol0;
  logic [AW0-1:0] hold_addr0;

  always @(negedge clk) begin
    beat_t e;
    if (!reset_n0) begin
      stall0    = 1'b0;
      done_exp0 = 1'b0;
    end else begin
      if (frame_done0 || done_exp0) check("dut0 frame_done", frame_done0, done_exp0);
      if (frame_done0) done_cnt0++;
      done_exp0 = 1'b0;
      if (stall0) begin
        check("dut0 hold m_valid", m_valid0, 1'b1);
        check("dut0 hold m_data", m_data0, hold_data0);
        check("dut0 hold m_sof", m_sof0, hold_sof0);
        check("dut0 hold m_eol", m_eol0, hold_eol0);
        check("dut0 hold rom_addr", rom_addr0, hold_addr0);
      end
      if (m_valid0 && m_ready0) begin
        if (q0.size() == 0) begin
          check("dut0 unexpected beat", 1, 0);
        end else begin
          e = q0.pop_front();
          check("dut0 m_data", m_data0, e.data);
          check("dut0 m_sof", m_sof0, e.sof);
          check("dut0 m_eol", m_eol0, e.eol);
          done_exp0 = e.last;
          beats0++;
        end
      end
      stall0     = m_valid0 && !m_ready0;
      hold_data0 = m_data0;
      hold_sof0  = m_sof0;
      hold_eol0  = m_eol0;
      hold_addr0 = rom_addr0;
    end
  end

  // ------------------------------------------------------------ monitor dut1
  bit started1 = 1'b0, done_exp1 = 1'b0;

  always @(negedge clk) begin
    beat_t e;
    if (!reset_n1) begin
      started1  = 1'b0;
      done_exp1 = 1'b0;
    end else begin
      if (frame_done1 || done_exp1) check("dut1 frame_done", frame_done1, done_exp1);
      if (frame_done1) done_cnt1++;
      done_exp1 = 1'b0;
      if (started1) check("dut1 no valid gap", m_valid1, 1'b1);
      if (m_valid1) started1 = 1'b1;
      if (m_valid1 && m_ready1) begin
        if (q1.size() == 0) begin
          check("dut1 unexpected beat", 1, 0);
        end else begin
          e = q1.pop_front();
          check("dut1 m_data", m_data1, e.data);
          check("dut1 m_sof", m_sof1, e.sof);
          check("dut1 m_eol", m_eol1, e.eol);
          done_exp1 = e.last;
          beats1++;
        end
      end
    end
  end

  // ------------------------------------------------------------ stimulus
  task automatic start_frame0();
    push_frame(0, H0, V0);
    @(posedge clk); #2 start0 = 1'b1;
    @(posedge clk); #2 start0 = 1'b0;
    @(negedge clk);
    check("dut0 busy after start", busy0, 1'b1);
    check("dut0 m_valid one edge after start", m_valid0, 1'b0);
    @(negedge clk);
    check("dut0 m_valid two edges after start", m_valid0, 1'b1);
  endtask

  task automatic wait_done0(input string name);
    int n = 0;
    while (!frame_done0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check({name, " frame_done seen"}, (n < 500), 1'b1);
    check({name, " busy after done"}, busy0, 1'b0);
    @(negedge clk);
  endtask

  task automatic wait_beats0(input int target);
    int n = 0;
    while (beats0 < target && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("dut0 beats reached", (n < 500), 1'b1);
  endtask

  initial begin
    int base, dbase, n;
    reset_n0 = 1'b0; reset_n1 = 1'b0;
    start0   = 1'b0; start1   = 1'b0;
    m_ready1 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset m_valid0", m_valid0, 1'b0);
    check("reset busy0", busy0, 1'b0);
    check("reset frame_done0", frame_done0, 1'b0);
    check("reset m_data0", m_data0, 16'h0);
    check("reset m_sof0", m_sof0, 1'b0);
    check("reset m_eol0", m_eol0, 1'b0);
    check("reset rom_addr0", rom_addr0, '0);
    check("reset m_valid1", m_valid1, 1'b0);
    @(posedge clk); #2 reset_n0 = 1'b1; reset_n1 = 1'b1;

    // Frame A: m_ready held high.
    base = beats0; dbase = done_cnt0;
    start_frame0();
    wait_done0("frameA");
    check("frameA beat count", beats0 - base, H0 * V0);
    check("frameA done pulses", done_cnt0 - dbase, 1);
    check("frameA queue empty", q0.size(), 0);

    // Frame B: random backpressure, start pulsed mid-frame must be ignored.
    rnd0 = 1'b1;
    base = beats0; dbase = done_cnt0;
    start_frame0();
    wait_beats0(base + 5);
    @(posedge clk); #2 start0 = 1'b1;
    @(posedge clk); #2 start0 = 1'b0;
    wait_done0("frameB");
    repeat (4) @(negedge clk);
    check("frameB beat count", beats0 - base, H0 * V0);
    check("frameB done pulses", done_cnt0 - dbase, 1);
    check("frameB queue empty", q0.size(), 0);
    check("frameB idle after ignored start", busy0, 1'b0);
    rnd0 = 1'b0;

    // Frame C: reset asserted mid-run.
    base = beats0;
    start_frame0();
    wait_beats0(base + 5);
    @(posedge clk); #3 reset_n0 = 1'b0;
    #1;
    check("midreset m_valid0", m_valid0, 1'b0);
    check("midreset busy0", busy0, 1'b0);
    check("midreset frame_done0", frame_done0, 1'b0);
    check("midreset rom_addr0", rom_addr0, '0);
    q0.delete();
    @(posedge clk); #2 reset_n0 = 1'b1;

    // Frame D: fresh start after reset begins at addr 0 with m_sof.
    base = beats0; dbase = done_cnt0;
    start_frame0();
    wait_done0("frameD");
    check("frameD beat count", beats0 - base, H0 * V0);
    check("frameD done pulses", done_cnt0 - dbase, 1);

    // Continuous mode on dut1: three full frames plus the wrap into the fourth.
    for (int f = 0; f < 4; f++) push_frame(1, H1, V1);
    @(posedge clk); #2 start1 = 1'b1;
    @(posedge clk); #2 start1 = 1'b0;
    @(negedge clk);
    check("dut1 busy after start", busy1, 1'b1);
    check("dut1 m_valid one edge after start", m_valid1, 1'b0);
    @(negedge clk);
    check("dut1 m_valid two edges after start", m_valid1, 1'b1);
    n = 0;
    while (beats1 < 3 * H1 * V1 + 2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("dut1 beats reached", (n < 500), 1'b1);
    @(negedge clk);
    check("dut1 done pulses after 3 frames", done_cnt1, 3);
    check("dut1 still busy", busy1, 1'b1);
    @(posedge clk); #3 reset_n1 = 1'b0;
    #1;
    check("dut1 reset m_valid", m_valid1, 1'b0);
    check("dut1 reset busy", busy1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
